// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage data-memory request/response bundle
interface dmem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        ack_o;
    logic        stall_o;
    logic        err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  rdata_o, ack_o, stall_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output rdata_o, ack_o, stall_o, err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable wait latency (optional DMEM_ALIGN_CHECK_EN)
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8,
    parameter int LATENCY     = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    dmem_responder_if.slave bus
);

    localparam bit ZERO_LAT = (LATENCY == 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        ack_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic              do_access;
    logic              acc_we;
    logic              acc_err;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [ADDR_W-1:0] acc_idx;

    // Access fields: live inputs when a zero-latency access fires at the accept edge, latched copy otherwise
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state == IDLE) begin
            acc_we    = bus.we_i;
            acc_addr  = bus.addr_i;
            acc_wdata = bus.wdata_i;
        end
        do_access = ((state == IDLE) && bus.req_i && ZERO_LAT) ||
                    ((state == WAIT) && (cnt == 4'd1));
        acc_idx   = acc_addr[ADDR_W+1:2];
    end

`ifdef DMEM_ALIGN_CHECK_EN
    // Misaligned or out-of-range byte addresses are rejected instead of wrapping
    assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr >= 32'(4 * DEPTH_WORDS));
`else
    // Low byte-offset bits and bits above the word index alias onto the array
    logic unused_addr_bits;
    assign unused_addr_bits = ^{acc_addr[31:ADDR_W+2], acc_addr[1:0]};
    assign acc_err = 1'b0;
`endif

    // Storage array: written only on a good store at its access edge, never reset
    always_ff @(posedge clk_i) begin
        if (do_access && acc_we && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    // Control FSM with registered response outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_i) begin
                        we_q    <= bus.we_i;
                        addr_q  <= bus.addr_i;
                        wdata_q <= bus.wdata_i;
                        cnt     <= 4'(LATENCY);
                        state   <= ZERO_LAT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (do_access) begin
                ack_q   <= 1'b1;
                err_q   <= acc_err;
                rdata_q <= (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
            end
        end
    end

    assign bus.rdata_o = rdata_q;
    assign bus.ack_o   = ack_q;
    assign bus.err_o   = err_q;
    assign bus.stall_o = bus.req_i & ~ack_q;

endmodule
